// File: rtl/univ_shift_reg_n_if.sv
// Universal shift register command/result bundle: a controller drives the command side,
// and the shift register returns its contents, serial taps and busy/done status.
interface univ_shift_reg_n_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic             start;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out_msb;
  logic             serial_out_lsb;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, amount, parallel_in, serial_in,
    input  parallel_out, serial_out_msb, serial_out_lsb, busy, done
  );

  modport slave (
    input  start, mode, amount, parallel_in, serial_in,
    output parallel_out, serial_out_msb, serial_out_lsb, busy, done
  );
endinterface

// File: rtl/univ_shift_reg_n.sv
// Parametrised universal shift register: load/hold/shift/rotate one operation at a time, with a start/busy/done handshake.
// Iterative by default (one step per cycle in RUN); defining SHIFT_BARREL_EN completes every operation on the accepting edge.
module univ_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  univ_shift_reg_n_if.slave    bus
);

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             fill_q, fill_d;

  logic [AMT_W-1:0] count_c;
  logic             is_shift_c;

  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v,
                                             input logic [2:0] m,
                                             input logic f);
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      MODE_SHL: r = {v[WIDTH-2:0], f};
      MODE_SHR: r = {f, v[WIDTH-1:1]};
      MODE_ROL: r = {v[WIDTH-2:0], v[WIDTH-1]};
      MODE_ROR: r = {v[0], v[WIDTH-1:1]};
      MODE_ASR: r = {v[WIDTH-1], v[WIDTH-1:1]};
      default:  r = v;
    endcase
    return r;
  endfunction

`ifdef SHIFT_BARREL_EN
  // Double-width concatenations let a single shift cover n == WIDTH without special cases.
  function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] v,
                                              input logic [2:0] m,
                                              input logic f,
                                              input logic [AMT_W-1:0] n);
    logic [2*WIDTH-1:0] cat;
    logic [WIDTH-1:0]   r;
    cat = '0;
    r   = v;
    case (m)
      MODE_SHL: begin cat = {v, {WIDTH{f}}} << n;        r = cat[2*WIDTH-1:WIDTH]; end
      MODE_SHR: begin cat = {{WIDTH{f}}, v} >> n;        r = cat[WIDTH-1:0];       end
      MODE_ROL: begin cat = {v, v} << n;                 r = cat[2*WIDTH-1:WIDTH]; end
      MODE_ROR: begin cat = {v, v} >> n;                 r = cat[WIDTH-1:0];       end
      MODE_ASR: begin cat = {{WIDTH{v[WIDTH-1]}}, v} >> n; r = cat[WIDTH-1:0];     end
      default:  r = v;
    endcase
    return r;
  endfunction
`endif

  assign count_c    = (bus.amount > AMT_MAX) ? AMT_MAX : bus.amount;
  assign is_shift_c = (bus.mode >= MODE_SHL) && (bus.mode <= MODE_ASR);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    case (state_q)
      ST_RUN: begin
        data_d = step1(data_q, mode_q, fill_q);
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
        if (bus.start) begin
          mode_d  = bus.mode;
          fill_d  = bus.serial_in;
          state_d = ST_DONE;
          if (bus.mode == MODE_LOAD) begin
            data_d = bus.parallel_in;
          end else if (is_shift_c && (count_c != '0)) begin
`ifdef SHIFT_BARREL_EN
            data_d = barrel(data_q, bus.mode, bus.serial_in, count_c);
`else
            state_d = ST_RUN;
            cnt_d   = count_c;
`endif
          end
        end
      end
    endcase
  end

  // Reset also aborts an in-flight operation and discards its partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
    end
  end

  assign bus.parallel_out   = data_q;
  assign bus.serial_out_msb = data_q[WIDTH-1];
  assign bus.serial_out_lsb = data_q[0];
  assign bus.busy           = (state_q == ST_RUN);
  assign bus.done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Directed bench for univ_shift_reg_n at WIDTH=8; expected latencies follow SHIFT_BARREL_EN when defined.
module tb_univ_shift_reg_n;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   lat;
  int   bcyc;

  univ_shift_reg_n_if #(.WIDTH(8), .AMT_W(4)) bus ();

  univ_shift_reg_n #(.WIDTH(8), .AMT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SHIFT_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  function automatic int exp_lat(input int n);
    return BARREL ? 1 : n + 1;
  endfunction

  function automatic int exp_busy(input int n);
    return BARREL ? 0 : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int l, output int b);
    l = 1;
    b = 0;
    while (bus.done !== 1'b1 && l < 40) begin
      if (bus.busy === 1'b1) b++;
      tick();
      l++;
    end
  endtask

  task automatic run_op(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d,
                        input logic s, output int l, output int b);
    bus.start       = 1'b1;
    bus.mode        = m;
    bus.amount      = a;
    bus.parallel_in = d;
    bus.serial_in   = s;
    tick();
    bus.start = 1'b0;
    wait_done(l, b);
  endtask

  task automatic load_e5();
    int l, b;
    run_op(3'd1, 4'd0, 8'hE5, 1'b0, l, b);
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    bus.start = 1'b0;
    bus.mode = 3'd0;
    bus.amount = 4'd0;
    bus.parallel_in = 8'h00;
    bus.serial_in = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    check("reset_out", 32'(bus.parallel_out), 32'h00);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    reset = 1'b0;
    tick();

    // LOAD then SHL 1
    run_op(3'd1, 4'd0, 8'hE5, 1'b0, lat, bcyc);
    check("load_lat", 32'(lat), 32'(1));
    check("load_out", 32'(bus.parallel_out), 32'hE5);
    check("load_msb", 32'(bus.serial_out_msb), 32'h1);
    check("load_lsb", 32'(bus.serial_out_lsb), 32'h1);
    tick();
    check("done_one_cycle", 32'(bus.done), 32'h0);
    run_op(3'd2, 4'd1, 8'h00, 1'b0, lat, bcyc);
    check("shl1_out", 32'(bus.parallel_out), 32'hCA);
    check("shl1_lat", 32'(lat), 32'(exp_lat(1)));
    check("shl1_busy", 32'(bcyc), 32'(exp_busy(1)));
    check("shl1_lsb", 32'(bus.serial_out_lsb), 32'h0);
    tick();

    // Inputs without start have no effect
    bus.mode = 3'd1;
    bus.parallel_in = 8'h77;
    tick();
    tick();
    check("idle_no_start", 32'(bus.parallel_out), 32'hCA);

    load_e5();
    run_op(3'd3, 4'd1, 8'h00, 1'b1, lat, bcyc);
    check("shr1_fill_out", 32'(bus.parallel_out), 32'hF2);
    check("shr1_lat", 32'(lat), 32'(exp_lat(1)));
    tick();

    load_e5();
    run_op(3'd6, 4'd2, 8'h00, 1'b0, lat, bcyc);
    check("asr2_out", 32'(bus.parallel_out), 32'hF9);
    check("asr2_lat", 32'(lat), 32'(exp_lat(2)));
    tick();

    load_e5();
    run_op(3'd4, 4'd3, 8'h00, 1'b0, lat, bcyc);
    check("rol3_out", 32'(bus.parallel_out), 32'h2F);
    check("rol3_lat", 32'(lat), 32'(exp_lat(3)));
    tick();

    load_e5();
    run_op(3'd5, 4'd8, 8'h00, 1'b0, lat, bcyc);
    check("ror8_out", 32'(bus.parallel_out), 32'hE5);
    check("ror8_lat", 32'(lat), 32'(exp_lat(8)));
    check("ror8_busy", 32'(bcyc), 32'(exp_busy(8)));
    tick();

    // amount 12 clamps to 8
    load_e5();
    run_op(3'd2, 4'd12, 8'h00, 1'b0, lat, bcyc);
    check("shl12_out", 32'(bus.parallel_out), 32'h00);
    check("shl12_lat", 32'(lat), 32'(exp_lat(8)));
    tick();

    load_e5();
    run_op(3'd3, 4'd0, 8'h00, 1'b1, lat, bcyc);
    check("shr0_out", 32'(bus.parallel_out), 32'hE5);
    check("shr0_lat", 32'(lat), 32'(1));
    check("shr0_busy", 32'(bcyc), 32'(0));
    tick();

    run_op(3'd0, 4'd3, 8'h11, 1'b1, lat, bcyc);
    check("hold_out", 32'(bus.parallel_out), 32'hE5);
    check("hold_lat", 32'(lat), 32'(1));
    tick();
    run_op(3'd7, 4'd3, 8'h11, 1'b1, lat, bcyc);
    check("rsvd_out", 32'(bus.parallel_out), 32'hE5);
    check("rsvd_lat", 32'(lat), 32'(1));
    tick();

`ifndef SHIFT_BARREL_EN
    // start pulsed during RUN must be ignored
    bus.start = 1'b1;
    bus.mode = 3'd4;
    bus.amount = 4'd3;
    tick();
    check("run_busy", 32'(bus.busy), 32'h1);
    bus.mode = 3'd1;
    bus.parallel_in = 8'h3C;
    tick();
    bus.start = 1'b0;
    wait_done(lat, bcyc);
    check("ignore_start_out", 32'(bus.parallel_out), 32'h2F);
    check("ignore_start_lat", 32'(lat + 1), 32'(4));
    tick();
`endif

    // Back-to-back: start held through the DONE cycle
    bus.start = 1'b1;
    bus.mode = 3'd1;
    bus.parallel_in = 8'hE5;
    tick();
    check("b2b_first_done", 32'(bus.done), 32'h1);
    bus.mode = 3'd2;
    bus.amount = 4'd1;
    bus.serial_in = 1'b0;
    tick();
    bus.start = 1'b0;
    check("b2b_accepted_busy", 32'(bus.busy), 32'(BARREL ? 0 : 1));
    wait_done(lat, bcyc);
    check("b2b_out", 32'(bus.parallel_out), 32'hCA);
    check("b2b_lat", 32'(lat), 32'(exp_lat(1)));
    tick();

    // Reset in the 2nd RUN cycle of ROL 5
    load_e5();
    bus.start = 1'b1;
    bus.mode = 3'd4;
    bus.amount = 4'd5;
    tick();
    bus.start = 1'b0;
    tick();
    check("mid_busy", 32'(bus.busy), 32'(BARREL ? 0 : 1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_out", 32'(bus.parallel_out), 32'h00);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_done", 32'(bus.done), 32'h0);
    tick();
    check("midrst_stays", 32'(bus.parallel_out), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
